fm_iq_modulator: RTL and testbench

Transmit-side counterpart of the FM IQ demodulation chain. Converts a stream of signed baseband samples (audio or frequency deviation) into an FM-modulated complex baseband. It uses a phase accumulator and a time-shared quarter-wave sine ROM. I and Q are emitted interleaved on one 12-bit bus, I then Q, one pair every 2 clocks, matching the interleaved IQ format the receive path consumes.

---
 rtl/fm_tx_pkg.sv | 29 ++
 rtl/quarter_sine_rom.sv | 31 +++
 rtl/fm_iq_modulator.sv | 149 ++++++++++++++
 tb/tb_fm_iq_modulator.sv | 194 +++++++++++++++++++
 4 files changed

// File: rtl/fm_tx_pkg.sv
// Shared constants for the FM transmit chain: default widths, quadrant and
// slot encodings, and the pipeline side-band tag carried alongside ROM reads.
package fm_tx_pkg;

    localparam int DEF_IN_W       = 12;
    localparam int DEF_PHASE_W    = 24;
    localparam int DEF_LUT_ADDR_W = 10;
    localparam int DEF_OUT_W      = 12;
    localparam int DEF_DEV_SHIFT  = 8;

    localparam real PI = 3.14159265358979323846;

    // Top two bits of the phase index select the quadrant
    localparam logic [1:0] Q0 = 2'd0;
    localparam logic [1:0] Q1 = 2'd1;
    localparam logic [1:0] Q2 = 2'd2;
    localparam logic [1:0] Q3 = 2'd3;

    // Interleave slot: I word first, then Q word
    localparam logic SLOT_I = 1'b0;
    localparam logic SLOT_Q = 1'b1;

    // Side-band that travels with a ROM lookup down the pipeline
    typedef struct packed {
        logic neg;  // quadrant 2/3: negate the magnitude
        logic sel;  // slot the lookup belongs to
    } lut_tag_t;

endpackage

// File: rtl/quarter_sine_rom.sv
// Quarter-wave sine magnitude ROM, synchronous read, one cycle of latency.
// Entry k holds round(AMP * sin(2*pi*(k+0.5)/(4*DEPTH))); the half-step
// offset keeps every entry nonzero and makes the mirrored quadrants exact.
module quarter_sine_rom
    import fm_tx_pkg::*;
#(
    parameter int ADDR_W = DEF_LUT_ADDR_W,
    parameter int DATA_W = DEF_OUT_W - 1
) (
    input  logic              clk,
    input  logic [ADDR_W-1:0] addr,
    output logic [DATA_W-1:0] data
);

    localparam int  DEPTH = 1 << ADDR_W;
    localparam real AMP   = real'((1 << DATA_W) - 1);

    logic [DATA_W-1:0] tbl [DEPTH];

    for (genvar k = 0; k < DEPTH; k++) begin : g_tbl
        localparam real ANG = 2.0 * PI * (real'(k) + 0.5) / real'(4 * DEPTH);
        localparam int  VAL = $rtoi(AMP * $sin(ANG) + 0.5);
        assign tbl[k] = DATA_W'(VAL);
    end

    // Registered read
    always_ff @(posedge clk) begin
        data <= tbl[addr];
    end

endmodule

// File: rtl/fm_iq_modulator.sv
// FM modulator: phase accumulator driven by carrier word plus scaled sample,
// one shared quarter-wave ROM time-sliced between cos (I) and sin (Q).
// Output is interleaved I,Q on a single bus, one pair every two clocks.
module fm_iq_modulator
    import fm_tx_pkg::*;
#(
    parameter int IN_W       = DEF_IN_W,
    parameter int PHASE_W    = DEF_PHASE_W,
    parameter int LUT_ADDR_W = DEF_LUT_ADDR_W,
    parameter int OUT_W      = DEF_OUT_W,
    parameter int DEV_SHIFT  = DEF_DEV_SHIFT
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [PHASE_W-1:0] fc_word,
    input  logic [IN_W-1:0]    sample,
    input  logic               sample_valid,
    output logic               sample_ready,
    output logic [OUT_W-1:0]   iq_out,
    output logic               iq_sel,
    output logic               iq_valid,
    output logic               underrun
);

    localparam int P_W    = LUT_ADDR_W + 2;
    localparam int DEPTH  = 1 << LUT_ADDR_W;
    // vld_pipe[0] = address stage, [1] = ROM stage, [2] = output stage
    localparam int STAGES = 2;

    logic                  slot;
    logic                  pending;
    logic                  seen_sample;
    logic [IN_W-1:0]       hold;
    logic [PHASE_W-1:0]    freq;
    logic [PHASE_W-1:0]    phase_acc;
    logic [PHASE_W-1:0]    dev;
    logic                  consume;
    logic                  accept;

    logic [P_W-1:0]        p_lut;
    logic [1:0]            quad;
    logic [LUT_ADDR_W-1:0] lut_addr;
    lut_tag_t              tag0;

    logic [LUT_ADDR_W-1:0] addr_r;
    lut_tag_t              tag1;
    lut_tag_t              tag2;
    logic [OUT_W-2:0]      rom_data;
    logic [OUT_W-1:0]      mag;
    logic [STAGES:0]       vld_pipe;

    assign consume      = (slot == SLOT_Q) & pending;
    assign sample_ready = ~pending | consume;
    assign accept       = sample_valid & sample_ready;
    assign dev          = {{(PHASE_W-IN_W){hold[IN_W-1]}}, hold} << DEV_SHIFT;

    // Slot toggle and one-entry input buffer
    always_ff @(posedge clk) begin
        if (reset) begin
            slot        <= SLOT_I;
            pending     <= 1'b0;
            seen_sample <= 1'b0;
            hold        <= '0;
        end else begin
            slot <= ~slot;
            if (accept) begin
                pending     <= 1'b1;
                hold        <= sample;
                seen_sample <= 1'b1;
            end else if (consume) begin
                pending <= 1'b0;
            end
        end
    end

    // Frame-rate frequency/phase update; freq written here is used next frame
    always_ff @(posedge clk) begin
        if (reset) begin
            freq      <= '0;
            phase_acc <= '0;
            underrun  <= 1'b0;
        end else if (slot == SLOT_Q) begin
            phase_acc <= phase_acc + freq;
            if (pending)
                freq <= fc_word + dev;
            else if (seen_sample)
                underrun <= 1'b1;
        end
    end

    // Phase to ROM address: I slot adds a quarter turn (cos), odd quadrants mirror
    always_comb begin
        p_lut = phase_acc[PHASE_W-1 -: P_W];
        if (slot == SLOT_I)
            p_lut = p_lut + P_W'(DEPTH);
        quad     = p_lut[P_W-1 -: 2];
        lut_addr = p_lut[LUT_ADDR_W-1:0];
        if (quad == Q1 || quad == Q3)
            lut_addr = ~lut_addr;
        tag0.neg = (quad == Q2 || quad == Q3);
        tag0.sel = slot;
    end

    // Address stage and tag alignment with the ROM read
    always_ff @(posedge clk) begin
        if (reset) begin
            addr_r <= '0;
            tag1   <= '0;
            tag2   <= '0;
        end else begin
            addr_r <= lut_addr;
            tag1   <= tag0;
            tag2   <= tag1;
        end
    end

    quarter_sine_rom #(
        .ADDR_W (LUT_ADDR_W),
        .DATA_W (OUT_W - 1)
    ) u_rom (
        .clk  (clk),
        .addr (addr_r),
        .data (rom_data)
    );

    assign mag = {1'b0, rom_data};

    // Sign restore and output register
    always_ff @(posedge clk) begin
        if (reset) begin
            iq_out <= '0;
            iq_sel <= SLOT_I;
        end else begin
            iq_out <= tag2.neg ? -mag : mag;
            iq_sel <= tag2.sel;
        end
    end

    // Valid ramps in as the pipeline fills after reset
    always_ff @(posedge clk) begin
        if (reset)
            vld_pipe <= '0;
        else
            vld_pipe <= {vld_pipe[STAGES-1:0], 1'b1};
    end

    assign iq_valid = vld_pipe[STAGES];

endmodule

// File: tb/tb_fm_iq_modulator.sv
// Bench for fm_iq_modulator: a cycle model of the frame behaviour pushes the
// expected I/Q word for every address cycle; words are popped on iq_valid.
module tb_fm_iq_modulator;

    logic        clk = 1'b0;
    logic        reset;
    logic [23:0] fc_word;
    logic [11:0] sample;
    logic        sample_valid;
    logic        sample_ready;
    logic [11:0] iq_out;
    logic        iq_sel;
    logic        iq_valid;
    logic        underrun;

    always #5 clk = ~clk;

    fm_iq_modulator dut (
        .clk          (clk),
        .reset        (reset),
        .fc_word      (fc_word),
        .sample       (sample),
        .sample_valid (sample_valid),
        .sample_ready (sample_ready),
        .iq_out       (iq_out),
        .iq_sel       (iq_sel),
        .iq_valid     (iq_valid),
        .underrun     (underrun)
    );

    typedef struct packed {
        logic               sel;
        logic signed [31:0] val;
    } exp_t;

    exp_t sb[$];
    int   n_chk = 0;
    int   n_err = 0;

    // reference state
    logic        m_slot  = 1'b0;
    logic        m_pend  = 1'b0;
    logic        m_seen  = 1'b0;
    logic        m_under = 1'b0;
    logic [11:0] m_hold  = '0;
    logic [23:0] m_freq  = '0;
    logic [23:0] m_phase = '0;
    int          m_vc    = 0;

    // ideal sine at the centre of 4096-step phase bin idx, magnitude rounded
    function automatic int amp(int idx);
        real x;
        x = 2047.0 * $sin(2.0 * 3.14159265358979 * (real'(idx) + 0.5) / 4096.0);
        return (x < 0.0) ? -$rtoi(-x + 0.5) : $rtoi(x + 0.5);
    endfunction

    task automatic chk(input string tag, input logic signed [31:0] got,
                       input logic signed [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got %0d exp %0d", tag, got, exp);
        end
    endtask

    // one clock: check ready, advance model across the edge, check outputs
    task automatic cyc();
        logic        cons;
        logic        rdy;
        int          p;
        exp_t        e;
        logic [23:0] sx;
        cons = m_slot & m_pend;
        rdy  = !m_pend || cons;
        if (!reset)
            chk("ready", sample_ready, rdy);
        @(posedge clk);
        if (reset) begin
            m_slot = 0; m_pend = 0; m_seen = 0; m_under = 0;
            m_hold = '0; m_freq = '0; m_phase = '0; m_vc = 0;
            sb.delete();
        end else begin
            p = int'(m_phase[23:12]);
            e.sel = m_slot;
            e.val = m_slot ? amp(p) : amp((p + 1024) % 4096);
            sb.push_back(e);
            if (m_slot) begin
                m_phase = m_phase + m_freq;
                sx = {{12{m_hold[11]}}, m_hold};
                if (m_pend)      m_freq  = fc_word + (sx * 256);
                else if (m_seen) m_under = 1'b1;
            end
            if (sample_valid && rdy) begin
                m_pend = 1'b1; m_hold = sample; m_seen = 1'b1;
            end else if (cons) begin
                m_pend = 1'b0;
            end
            m_slot = !m_slot;
            m_vc++;
        end
        @(negedge clk);
        chk("iq_valid", iq_valid, m_vc >= 3);
        chk("underrun", underrun, m_under);
        if (iq_valid) begin
            chk("sb_nonempty", sb.size() != 0, 1);
            if (sb.size() != 0) begin
                e = sb.pop_front();
                chk("iq_sel", iq_sel, e.sel);
                chk("iq_out", $signed(iq_out), e.val);
            end
        end
    endtask

    task automatic do_reset();
        reset = 1'b1;
        sample_valid = 1'b0;
        cyc();
        reset = 1'b0;
    endtask

    initial begin
        reset = 1'b1; fc_word = '0; sample = '0; sample_valid = 1'b0;
        @(negedge clk);
        repeat (2) cyc();
        chk("rst_out", $signed(iq_out), 0);
        chk("rst_sel", iq_sel, 0);
        chk("rst_vld", iq_valid, 0);
        chk("rst_und", underrun, 0);

        // idle carrier at zero offset: constant (2047, 2)
        reset = 1'b0;
        repeat (20) cyc();
        chk("tp1_a", $signed(iq_out), iq_sel ? 2 : 2047);
        cyc();
        chk("tp1_b", $signed(iq_out), iq_sel ? 2 : 2047);
        chk("tp1_und", underrun, 0);

        // quarter turn per frame from one zero sample
        do_reset();
        fc_word = 24'h400000; sample = '0; sample_valid = 1'b1;
        cyc();
        sample_valid = 1'b0;
        repeat (40) cyc();

        // continuous samples of 4 -> deviation 1024 per frame
        do_reset();
        fc_word = '0; sample = 12'd4; sample_valid = 1'b1;
        repeat (40) cyc();
        chk("tp3_und", underrun, 0);

        // starve the input: underrun latches, freq holds
        sample_valid = 1'b0;
        repeat (6) cyc();
        chk("tp4_und", underrun, 1);
        repeat (10) cyc();

        // negative-going phase wraps 0 -> 0xFFFFFF
        do_reset();
        fc_word = 24'hFFFFFF; sample = '0; sample_valid = 1'b1;
        repeat (30) cyc();
        chk("tp5_a", $signed(iq_out), iq_sel ? -2 : 2047);
        cyc();
        chk("tp5_b", $signed(iq_out), iq_sel ? -2 : 2047);

        // random traffic
        do_reset();
        repeat (300) begin
            fc_word      = 24'($urandom);
            sample       = 12'($urandom);
            sample_valid = 1'($urandom_range(0, 1));
            cyc();
        end

        // reset mid-stream with a sample pending
        fc_word = 24'd1234567; sample = 12'd37; sample_valid = 1'b1;
        repeat (10) cyc();
        reset = 1'b1;
        cyc();
        chk("mr_vld", iq_valid, 0);
        chk("mr_und", underrun, 0);
        chk("mr_rdy", sample_ready, 1);
        reset = 1'b0; sample_valid = 1'b0;
        repeat (2) cyc();
        chk("mr_vld2", iq_valid, 0);
        cyc();
        chk("mr_vld3", iq_valid, 1);
        chk("mr_sel3", iq_sel, 0);
        repeat (8) cyc();

        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end

endmodule
